// File: rtl/pic_alu_seq.sv
// -----------------------------------------------------------------------------
// pic_alu_seq
//
// Sequential 8-bit ALU for the PIC10F200 core. One operation runs over a
// four-state Q-cycle sequence (Q1..Q4) and feeds the status register with a
// result byte, the C/DC/Z flag inputs and a load strobe at Q4. Flags that an
// operation does not touch are copied from the status value sampled in Q1, so
// the status register's three-bit load writes them back unchanged.
//
// Sequence:  IDLE -> Q1 -> Q2 -> Q3 -> Q4 -> IDLE (or Q1 if start_i in Q4)
//   accept : latch op/a/b
//   Q1     : latch status_in_i
//   Q2     : compute into an internal register
//   Q3     : copy into result_o / flag outputs
//   Q4     : done_o, s_load_o (when the op affects a flag)
//
// Configuration macro:
//   ALU_ROTATE_EN  defined   -> ops 9/10 are RLF/RRF through carry
//                  undefined -> ops 9/10 behave as reserved opcodes
//
// Ports:
//   clk_i        in   system clock, rising edge
//   rst_i        in   synchronous, active-high reset
//   start_i      in   one-cycle request, accepted in IDLE or Q4 only
//   op_i[3:0]    in   operation code, sampled with start_i
//   a_i          in   W operand, sampled with start_i
//   b_i          in   file/literal operand, sampled with start_i
//   status_in_i  in   current status bits {Z,DC,C}, sampled in Q1
//   busy_o       out  high in Q1..Q4
//   done_o       out  one-cycle pulse in Q4
//   result_o     out  registered result, held until the next Q3
//   fc_o         out  carry flag to status register
//   fdc_o        out  digit-carry flag to status register
//   fz_o         out  zero flag to status register
//   s_load_o     out  status load strobe, Q4 only, when a flag is affected
// -----------------------------------------------------------------------------
module pic_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       status_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             fc_o,
    output logic             fdc_o,
    output logic             fz_o,
    output logic             s_load_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_Q1,
        S_Q2,
        S_Q3,
        S_Q4
    } state_t;

    localparam logic [3:0] OP_MOVF = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_IOR  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_COM  = 4'd6;
    localparam logic [3:0] OP_INC  = 4'd7;
    localparam logic [3:0] OP_DEC  = 4'd8;
`ifdef ALU_ROTATE_EN
    localparam logic [3:0] OP_RLF  = 4'd9;
    localparam logic [3:0] OP_RRF  = 4'd10;
`endif
    localparam logic [3:0] OP_SWAP = 4'd11;
    localparam logic [3:0] OP_CLR  = 4'd12;
    localparam logic [3:0] OP_MOVW = 4'd13;

    state_t           state_q, state_d;
    logic             accept;

    // Operands captured at accept, status captured in Q1.
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       st_q;          // {Z,DC,C}

    // Q2 compute stage.
    logic [WIDTH-1:0] alu_res_d, alu_res_q;
    logic [2:0]       alu_flg_d, alu_flg_q;   // {Z,DC,C}
    logic             alu_ld_d, alu_ld_q;

    // Q3 output stage.
    logic [WIDTH-1:0] result_q;
    logic [2:0]       flg_q;
    logic             load_q;

    logic [WIDTH:0]   sum_add, sum_sub;
    logic             c_new, dc_new, z_aff;

    assign accept = start_i & ((state_q == S_IDLE) | (state_q == S_Q4));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_Q1 : S_IDLE;
            S_Q1:    state_d = S_Q2;
            S_Q2:    state_d = S_Q3;
            S_Q3:    state_d = S_Q4;
            S_Q4:    state_d = accept ? S_Q1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy_o   = (state_q != S_IDLE);
        done_o   = (state_q == S_Q4);
        s_load_o = (state_q == S_Q4) & load_q;
    end

    assign result_o = result_q;
    assign fz_o     = flg_q[2];
    assign fdc_o    = flg_q[1];
    assign fc_o     = flg_q[0];

    // -------------------------------------------------------------------------
    // ALU (evaluated on the latched operands, registered in Q2)
    // -------------------------------------------------------------------------
    // Carry into bit 4 equals carry out of bit 3: recover it from bit 4 of the
    // sum and the two addend bits.
    assign sum_add = {1'b0, a_q} + {1'b0, b_q};
    assign sum_sub = {1'b0, b_q} + {1'b0, ~a_q} + (WIDTH+1)'(1);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        alu_res_d = '0;
        c_new     = st_q[0];
        dc_new    = st_q[1];
        z_aff     = 1'b0;
        alu_ld_d  = 1'b0;
        case (op_q)
            OP_MOVF: begin alu_res_d = b_q;        z_aff = 1'b1; alu_ld_d = 1'b1; end
            OP_ADD: begin
                alu_res_d = sum_add[WIDTH-1:0];
                c_new     = sum_add[WIDTH];
                dc_new    = sum_add[4] ^ a_q[4] ^ b_q[4];
                z_aff     = 1'b1;
                alu_ld_d  = 1'b1;
            end
            OP_SUB: begin
                // Carry set means no borrow (b >= a), PIC convention.
                alu_res_d = sum_sub[WIDTH-1:0];
                c_new     = sum_sub[WIDTH];
                dc_new    = sum_sub[4] ^ b_q[4] ^ ~a_q[4];
                z_aff     = 1'b1;
                alu_ld_d  = 1'b1;
            end
            OP_AND:  begin alu_res_d = a_q & b_q;  z_aff = 1'b1; alu_ld_d = 1'b1; end
            OP_IOR:  begin alu_res_d = a_q | b_q;  z_aff = 1'b1; alu_ld_d = 1'b1; end
            OP_XOR:  begin alu_res_d = a_q ^ b_q;  z_aff = 1'b1; alu_ld_d = 1'b1; end
            OP_COM:  begin alu_res_d = ~b_q;       z_aff = 1'b1; alu_ld_d = 1'b1; end
            OP_INC:  begin alu_res_d = b_q + WIDTH'(1); z_aff = 1'b1; alu_ld_d = 1'b1; end
            OP_DEC:  begin alu_res_d = b_q - WIDTH'(1); z_aff = 1'b1; alu_ld_d = 1'b1; end
`ifdef ALU_ROTATE_EN
            OP_RLF: begin
                alu_res_d = {b_q[WIDTH-2:0], st_q[0]};
                c_new     = b_q[WIDTH-1];
                alu_ld_d  = 1'b1;
            end
            OP_RRF: begin
                alu_res_d = {st_q[0], b_q[WIDTH-1:1]};
                c_new     = b_q[0];
                alu_ld_d  = 1'b1;
            end
`endif
            OP_SWAP: alu_res_d = {b_q[3:0], b_q[WIDTH-1:4]};
            OP_CLR:  begin alu_res_d = '0;         z_aff = 1'b1; alu_ld_d = 1'b1; end
            OP_MOVW: alu_res_d = a_q;
            default: alu_res_d = '0;   // reserved: zero result, flags untouched
        endcase
        alu_flg_d = {(z_aff ? (alu_res_d == '0) : st_q[2]), dc_new, c_new};
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            st_q      <= '0;
            alu_res_q <= '0;
            alu_flg_q <= '0;
            alu_ld_q  <= 1'b0;
            result_q  <= '0;
            flg_q     <= '0;
            load_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_i;
                a_q  <= a_i;
                b_q  <= b_i;
            end
            if (state_q == S_Q1) begin
                st_q <= status_in_i;
            end
            if (state_q == S_Q2) begin
                alu_res_q <= alu_res_d;
                alu_flg_q <= alu_flg_d;
                alu_ld_q  <= alu_ld_d;
            end
            if (state_q == S_Q3) begin
                result_q <= alu_res_q;
                flg_q    <= alu_flg_q;
                load_q   <= alu_ld_q;
            end
        end
    end

endmodule

// File: tb/tb_pic_alu_seq.sv
// -----------------------------------------------------------------------------
// Testbench for pic_alu_seq: a table of directed operations with hand-computed
// results and flags, followed by hand-written sequences for start in Q2,
// back-to-back start in Q4, and reset in the middle of an operation.
// Flags are compared as {fz,fdc,fc}.
// -----------------------------------------------------------------------------
module tb_pic_alu_seq;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] st;    // status_in {Z,DC,C}
        logic [7:0] res;
        logic [2:0] flg;   // expected {fz,fdc,fc}
        logic       ld;    // expected s_load in Q4
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [2:0] status_in;
    logic       busy, done, fc, fdc, fz, s_load;
    logic [7:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pic_alu_seq #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .status_in_i (status_in),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result),
        .fc_o        (fc),
        .fdc_o       (fdc),
        .fz_o        (fz),
        .s_load_o    (s_load)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One operation from IDLE; inputs are scrambled right after acceptance and
    // status_in after Q1 to show that the DUT works from its latched copies.
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b; status_in = v.st;
        @(negedge clk);                             // Q1
        start = 1'b0; op = ~v.op; a = ~v.a; b = ~v.b;
        check($sformatf("v%0d q1 busy", idx), busy, 1);
        check($sformatf("v%0d q1 done", idx), done, 0);
        @(negedge clk);                             // Q2
        status_in = ~v.st;
        check($sformatf("v%0d q2 sload", idx), s_load, 0);
        @(negedge clk);                             // Q3
        check($sformatf("v%0d q3 done", idx), done, 0);
        @(negedge clk);                             // Q4
        check($sformatf("v%0d q4 busy", idx), busy, 1);
        check($sformatf("v%0d q4 done", idx), done, 1);
        check($sformatf("v%0d q4 sload", idx), s_load, v.ld);
        check($sformatf("v%0d result", idx), result, v.res);
        check($sformatf("v%0d flags", idx), {fz, fdc, fc}, v.flg);
        @(negedge clk);                             // IDLE
        check($sformatf("v%0d idle busy", idx), busy, 0);
        check($sformatf("v%0d idle done", idx), done, 0);
        check($sformatf("v%0d hold result", idx), result, v.res);
    endtask

    initial begin
        int dcnt;

        //              op     a      b      st      res    flg     ld
        vecs.push_back({4'd0,  8'h00, 8'h00, 3'b011, 8'h00, 3'b111, 1'b1}); // MOVF zero
        vecs.push_back({4'd0,  8'h00, 8'h80, 3'b100, 8'h80, 3'b000, 1'b1}); // MOVF nonzero
        vecs.push_back({4'd1,  8'h0F, 8'h01, 3'b000, 8'h10, 3'b010, 1'b1}); // ADD DC
        vecs.push_back({4'd1,  8'hFF, 8'h01, 3'b000, 8'h00, 3'b111, 1'b1}); // ADD wrap
        vecs.push_back({4'd1,  8'h3C, 8'h4B, 3'b111, 8'h87, 3'b010, 1'b1}); // ADD
        vecs.push_back({4'd2,  8'h05, 8'h03, 3'b111, 8'hFE, 3'b000, 1'b1}); // SUB borrow
        vecs.push_back({4'd2,  8'h03, 8'h03, 3'b000, 8'h00, 3'b111, 1'b1}); // SUB equal
        vecs.push_back({4'd2,  8'h01, 8'h10, 3'b000, 8'h0F, 3'b001, 1'b1}); // SUB nibble borrow
        vecs.push_back({4'd3,  8'hF0, 8'h0F, 3'b001, 8'h00, 3'b101, 1'b1}); // AND
        vecs.push_back({4'd4,  8'h30, 8'h03, 3'b110, 8'h33, 3'b010, 1'b1}); // IOR
        vecs.push_back({4'd5,  8'h55, 8'h55, 3'b000, 8'h00, 3'b100, 1'b1}); // XOR
        vecs.push_back({4'd6,  8'h00, 8'hFF, 3'b011, 8'h00, 3'b111, 1'b1}); // COM
        vecs.push_back({4'd7,  8'h00, 8'hFF, 3'b000, 8'h00, 3'b100, 1'b1}); // INC wrap
        vecs.push_back({4'd7,  8'h00, 8'h41, 3'b100, 8'h42, 3'b000, 1'b1}); // INC
        vecs.push_back({4'd8,  8'h00, 8'h01, 3'b000, 8'h00, 3'b100, 1'b1}); // DEC to zero
        vecs.push_back({4'd8,  8'h00, 8'h00, 3'b100, 8'hFF, 3'b000, 1'b1}); // DEC wrap
`ifdef ALU_ROTATE_EN
        vecs.push_back({4'd9,  8'h00, 8'h80, 3'b101, 8'h01, 3'b101, 1'b1}); // RLF
        vecs.push_back({4'd10, 8'h00, 8'h01, 3'b000, 8'h00, 3'b001, 1'b1}); // RRF C out
        vecs.push_back({4'd10, 8'h00, 8'h02, 3'b001, 8'h81, 3'b000, 1'b1}); // RRF C in
`else
        vecs.push_back({4'd9,  8'h00, 8'h80, 3'b101, 8'h00, 3'b101, 1'b0}); // RLF disabled
        vecs.push_back({4'd10, 8'h00, 8'h01, 3'b000, 8'h00, 3'b000, 1'b0}); // RRF disabled
        vecs.push_back({4'd10, 8'h00, 8'h02, 3'b001, 8'h00, 3'b001, 1'b0}); // RRF disabled
`endif
        vecs.push_back({4'd11, 8'h00, 8'hA5, 3'b010, 8'h5A, 3'b010, 1'b0}); // SWAP
        vecs.push_back({4'd12, 8'h12, 8'h34, 3'b011, 8'h00, 3'b111, 1'b1}); // CLR
        vecs.push_back({4'd13, 8'h42, 8'h00, 3'b111, 8'h42, 3'b111, 1'b0}); // MOVW
        vecs.push_back({4'd14, 8'hFF, 8'hFF, 3'b101, 8'h00, 3'b101, 1'b0}); // reserved
        vecs.push_back({4'd15, 8'h01, 8'h02, 3'b010, 8'h00, 3'b010, 1'b0}); // reserved

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; status_in = '0;
        repeat (2) @(negedge clk);
        check("reset busy",   busy,   0);
        check("reset done",   done,   0);
        check("reset sload",  s_load, 0);
        check("reset result", result, 0);
        check("reset flags",  {fz, fdc, fc}, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // start pulsed in Q2 is ignored: one done only, result from first op.
        @(negedge clk);
        start = 1'b1; op = 4'd1; a = 8'h01; b = 8'h01; status_in = 3'b000;
        @(negedge clk);                             // Q1
        start = 1'b0;
        @(negedge clk);                             // Q2
        start = 1'b1; op = 4'd12; a = 8'h00; b = 8'h00;
        @(negedge clk);                             // Q3
        start = 1'b0;
        check("q2start q3 done", done, 0);
        @(negedge clk);                             // Q4
        check("q2start q4 done", done, 1);
        check("q2start result", result, 8'h02);
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        check("q2start extra done", dcnt, 0);
        check("q2start idle busy", busy, 0);

        // Back-to-back: start in Q4, second done 4 cycles later, status re-sampled.
        @(negedge clk);
        start = 1'b1; op = 4'd1; a = 8'hFF; b = 8'h01; status_in = 3'b000;
        @(negedge clk); start = 1'b0;               // Q1
        @(negedge clk);                             // Q2
        @(negedge clk);                             // Q3
        @(negedge clk);                             // Q4
        check("b2b first done", done, 1);
        check("b2b first result", result, 8'h00);
        check("b2b first flags", {fz, fdc, fc}, 3'b111);
        start = 1'b1; op = 4'd13; a = 8'h11; b = 8'h00;
        @(negedge clk);                             // Q1 of second op
        start = 1'b0; status_in = 3'b110;
        check("b2b q1 busy", busy, 1);
        check("b2b q1 done", done, 0);
        @(negedge clk);
        check("b2b q2 done", done, 0);
        @(negedge clk);
        check("b2b q3 done", done, 0);
        @(negedge clk);
        check("b2b second done", done, 1);
        check("b2b second result", result, 8'h11);
        check("b2b second flags", {fz, fdc, fc}, 3'b110);
        check("b2b second sload", s_load, 0);
        @(negedge clk);
        check("b2b idle busy", busy, 0);

        // Reset in Q2 aborts; start held with rst is dropped.
        @(negedge clk);
        start = 1'b1; op = 4'd1; a = 8'h22; b = 8'h11; status_in = 3'b000;
        @(negedge clk); start = 1'b0;               // Q1
        @(negedge clk);                             // Q2
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("rst busy",   busy,   0);
        check("rst done",   done,   0);
        check("rst sload",  s_load, 0);
        check("rst result", result, 0);
        check("rst flags",  {fz, fdc, fc}, 0);
        // Start immediately after reset release.
        rst = 1'b0; start = 1'b1; op = 4'd1; a = 8'h0F; b = 8'h01; status_in = 3'b000;
        @(negedge clk);                             // Q1
        start = 1'b0;
        check("post-rst q1 busy", busy, 1);
        check("post-rst q1 done", done, 0);
        @(negedge clk);
        check("post-rst q2 done", done, 0);
        @(negedge clk);
        check("post-rst q3 done", done, 0);
        @(negedge clk);
        check("post-rst done",   done,   1);
        check("post-rst sload",  s_load, 1);
        check("post-rst result", result, 8'h10);
        check("post-rst flags",  {fz, fdc, fc}, 3'b010);
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        check("post-rst extra done", dcnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_alu_seq.md
# pic_alu_seq

Sequential 8-bit ALU for the PIC10F200 core, sitting directly upstream of the status register. It executes one ALU operation over a four-state Q-cycle sequence (Q1–Q4). It produces the result byte, drives the `fc`/`fdc`/`fz` flag inputs of the status register, and pulses its `s_load` at Q4. Flags that an operation does not affect are passed through from the current status value, so the status register's three-bit load writes them back unchanged.

## Interface
- `WIDTH`, 8, datapath width; only 8 is supported.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted in IDLE or Q4 only.
- `op`  in  4  operation code, sampled with `start`.
- `a`  in  WIDTH  W operand, sampled with `start`.
- `b`  in  WIDTH  file/literal operand, sampled with `start`.
- `status_in`  in  3  current status bits {Z,DC,C} = status_bus[2:0], sampled in Q1.
- `busy`  out  1  high in Q1–Q4.
- `done`  out  1  one-cycle pulse in Q4.
- `result`  out  WIDTH  registered result, held until next Q3.
- `fc`, `fdc`, `fz`  out  1 each  registered flags to status register, held until next Q3.
- `s_load`  out  1  status load strobe, high in Q4 only when `op` affects at least one flag.

## Operation
- States: IDLE → Q1 → Q2 → Q3 → Q4 → IDLE. If `start` is high in Q4, the next state is Q1 instead.
- On accept, latch `op`, `a` and `b`.
- Q1: latch `status_in`.
- Q2: compute.
- Q3: register `result` and flags.
- Q4: assert `done`, and `s_load` if the op affects flags.
- `start` in Q1–Q3 is ignored and is not queued.
- Ops (flags affected; all others take the latched `status_in` value):
  - 0 MOVF: b (Z).
  - 1 ADD: a+b (C, DC, Z).
    - C = carry out of bit 7.
    - DC = carry out of bit 3.
  - 2 SUB: b−a, computed as b+~a+1 (C, DC, Z).
    - C = 1 when b≥a (no borrow).
    - DC = 1 when b[3:0]≥a[3:0].
  - 3 AND a&b (Z); 4 IOR a|b (Z); 5 XOR a^b (Z).
  - 6 COM ~b (Z); 7 INC b+1 (Z); 8 DEC b−1 (Z).
  - 9 RLF: {b[6:0],C}, new C=b[7]. 10 RRF: {C,b[7:1]}, new C=b[0]. Both affect C only.
  - 11 SWAP: {b[3:0],b[7:4]} (none).
  - 12 CLR: 0x00 (Z=1).
  - 13 MOVW: a (none).
  - 14, 15: reserved; result 0x00, no flags affected, `s_load`=0, `done` still pulses.
- Z = (result == 0). All arithmetic wraps modulo 256.
- Reset (any state): state IDLE; `busy`, `done`, `s_load`, `result`, `fc`, `fdc`, `fz` all 0. An operation in flight is aborted and produces no `done`.

## Timing
- `start` accepted at edge t:
  - `busy`=1 in cycles t+1..t+4.
  - `result` and flags are valid from t+4.
  - `done` and `s_load` are high in cycle t+4 only.
- Back-to-back: `start` in the Q4 cycle sustains one op per 4 cycles. The status register loads at the Q4 edge, so the next Q1 samples the updated `status_in`.
- `start` together with `rst`: reset wins, and the request is dropped.

## Configuration
- `ALU_ROTATE_EN` defined: ops 9/10 implement RLF/RRF as specified.
- `ALU_ROTATE_EN` undefined: ops 9/10 behave as reserved (result 0x00, no flags affected, `s_load`=0).

## Test plan
- ADD a=0x0F b=0x01 → result=0x10, fc=0 fdc=1 fz=0, `s_load`=1 and `done`=1 exactly 4 cycles after `start`; ADD a=0xFF b=0x01 → 0x00, fc=1 fdc=1 fz=1.
- SUB a=0x05 b=0x03 → 0xFE, fc=0 fdc=0 fz=0; SUB a=0x03 b=0x03 → 0x00, fc=1 fdc=1 fz=1.
- RLF b=0x80, status_in=3'b101 → 0x01, fc=1, fdc=0, fz=1 (both passed through). Rebuilt without `ALU_ROTATE_EN` → result 0x00, `s_load`=0, `done`=1.
- SWAP b=0xA5, status_in=3'b010 → 0x5A, `s_load`=0, flags {fz,fdc,fc}=3'b010; AND a=0xF0 b=0x0F → 0x00, fz=1, fc/fdc passed through.
- `start` pulsed in Q2 → ignored, single `done`. `start` in Q4 → second `done` exactly 4 cycles after the first, with status_in re-sampled.
- `rst` asserted in Q2 → next cycle `busy`=0 and all outputs 0, no `done`; `start` accepted immediately after reset.
